// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared constants, FSM state encoding and gate-length helper for freq_meter.
package freq_meter_pkg;

    localparam int unsigned BASE_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    function automatic int unsigned gate_cycles_ms(input int unsigned ms);
        return (BASE_FREQ / 1000) * ms;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: multi-flop synchronizer plus rising-edge detector for an asynchronous input.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_a_p,
    input  logic d_in,
    output logic rise_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_p = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_in over a GATE_CYCLES window and latches the result.
// Define FREQ_METER_PERIOD_EN to add period_out, the clk_in-cycle distance between consecutive edges.
module freq_meter #(
    parameter int unsigned BASE_FREQ   = freq_meter_pkg::BASE_FREQ,
    parameter int unsigned GATE_CYCLES = BASE_FREQ,
    parameter int          CNT_W       = 26,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_a_p,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_out
`endif
);

    import freq_meter_pkg::*;

    localparam int         GW      = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (GATE_CYCLES < 4 || SYNC_STAGES < 2 || BASE_FREQ == 0) begin : g_bad_cfg
        $error("freq_meter: GATE_CYCLES must be >= 4, SYNC_STAGES >= 2, BASE_FREQ > 0");
    end

    logic edge_p;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_a_p(rst_a_p),
        .d_in   (sig_in),
        .rise_p (edge_p)
    );

    state_t           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d, count_q, count_d;
    logic             sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt, last;

    // The final window cycle's edge is folded in before latching.
    assign cnt_nxt = (edge_p && edge_q != CNT_MAX) ? edge_q + 1'b1 : edge_q;
    assign sat_nxt = sat_q | (edge_p && edge_q == CNT_MAX);
    assign last    = gate_q == GW'(GATE_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        gate_d  = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = enable ? ST_GATE : ST_IDLE;
            ST_GATE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (last) begin
                    state_d = ST_LATCH;
                    count_d = cnt_nxt;
                    ovf_d   = sat_nxt;
                    valid_d = 1'b1;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = cnt_nxt;
                    sat_d  = sat_nxt;
                end
            end
            ST_LATCH: state_d = enable ? ST_GATE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count_out = count_q;
    assign overflow  = ovf_q;
    assign valid     = valid_q;
    assign busy      = state_q == ST_GATE;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_q, period_q;

    always_ff @(posedge clk_in or posedge rst_a_p) begin
        if (rst_a_p) begin
            per_q    <= '0;
            period_q <= '0;
        end else if (!enable) begin
            per_q <= '0;
        end else if (edge_p) begin
            period_q <= (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
            per_q    <= '0;
        end else if (per_q != CNT_MAX) begin
            per_q <= per_q + 1'b1;
        end
    end

    assign period_out = period_q;
`endif

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures an external or divided clock, such as a clock divider output, against the 50 MHz system clock.
- Counts synchronized rising edges of `sig_in` over a fixed gate window and latches the count.
- Raises a one-cycle `valid` strobe with each result.
- Serves as the consumer/checker end of the clock-division chain, driving on-board display and self-test logic.

Parameters:
- BASE_FREQ, 50_000_000, system clock frequency in Hz; used only to derive the default gate.
- GATE_CYCLES, BASE_FREQ (1 s gate), gate window length in `clk_in` cycles; must be ≥ 4.
- CNT_W, 26, width of the edge counter and `count_out`.
- SYNC_STAGES, 2, synchronizer depth for `sig_in`; must be ≥ 2.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- rst_a_p  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable; level-sensitive.
- sig_in  input  1  signal under measurement; asynchronous to `clk_in`.
- count_out  output  CNT_W  rising edges counted in the last completed gate.
- valid  output  1  one-cycle pulse when `count_out` updates.
- overflow  output  1  the last completed gate saturated the counter.
- busy  output  1  a gate window is in progress.

Behaviour:
- Clock and reset:
  - One clock, `clk_in`.
  - Reset `rst_a_p` is asynchronous and active-high.
  - While `rst_a_p` = 1, all flops clear: synchronizer stages = 0, edge-history flop = 0, counters = 0, `count_out` = 0, `valid` = 0, `overflow` = 0, `busy` = 0, state = IDLE.
- Input conditioning:
  - `sig_in` passes through SYNC_STAGES flops, then a rising-edge detector (`sync & ~sync_d`).
  - The edge pulse `edge_p` arrives SYNC_STAGES+1 cycles after the input transition.
  - Pulses narrower than one `clk_in` period may be missed; inputs above 25 MHz are out of spec.
- State machine (IDLE, GATE, LATCH):
  - IDLE: `busy` = 0. When `enable` = 1, go to GATE next cycle; `gate_cnt` = 0, `edge_cnt` = 0.
  - GATE: `busy` = 1.
    - `gate_cnt` increments every cycle.
    - `edge_cnt` increments on each `edge_p`, including the cycle `gate_cnt` == GATE_CYCLES-1.
    - When `gate_cnt` == GATE_CYCLES-1, go to LATCH.
    - The window is exactly GATE_CYCLES cycles.
  - LATCH: lasts one cycle.
    - `count_out` <= `edge_cnt`; `overflow` <= saturation flag; `valid` = 1 for this cycle only.
    - Counters clear.
    - If `enable` = 1, go back to GATE; otherwise go to IDLE.
    - An `edge_p` in the LATCH cycle is dropped; a continuous measurement has a one-cycle dead time per gate.
- Saturation: `edge_cnt` stops at 2^CNT_W−1. The saturation flag sets and holds until LATCH.
- `enable` deasserted mid-GATE:
  - Abort to IDLE next cycle and clear the counters.
  - No `valid` pulse; `count_out` and `overflow` keep the last latched result.
- `count_out` and `overflow` hold between updates. Downstream samples them on `valid`; there is no back-pressure.
- Reset asserted mid-gate: outputs clear immediately (asynchronously). After release, a new gate starts only via IDLE→GATE.
- Frequency in Hz = `count_out` × BASE_FREQ / GATE_CYCLES; with the default gate, this equals `count_out`.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- When defined, add output `period_out` [CNT_W] and a free-running period counter.
  - The counter counts `clk_in` cycles between consecutive `edge_p` pulses.
  - On each `edge_p`, `period_out` <= counter + 1 and the counter resets.
  - The counter saturates at max; it clears when `enable` = 0 and on reset.
  - It runs independently of the gate state machine.
  - `period_out` resets to 0.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package freq_meter_pkg holds:
  - The BASE_FREQ constant (50_000_000).
  - The state encoding constants ST_IDLE = 2'd0, ST_GATE = 2'd1, ST_LATCH = 2'd2.
  - A helper function computing gate cycles from milliseconds.
- Sub-module sync_edge (parameter SYNC_STAGES; ports `clk_in`, `rst_a_p`, `d_in`, `rise_p`) implements the synchronizer and rising-edge detector. It is reusable for buttons and other async inputs.

Test Plan:
- Reset and enable:
  - GATE_CYCLES=1000, `enable` held 0 for 2000 cycles → `busy`=0, `valid` never asserts, `count_out`=0.
  - Assert `rst_a_p` mid-gate → `count_out`, `overflow`, and `busy` drop to 0 within the same cycle.
- Basic count: GATE_CYCLES=1000, `sig_in` clock-synchronous with period 10 cycles (starts 0), `enable`=1 from reset release.
  - First `valid` at cycle 1001 after enable.
  - `count_out` = 100, `overflow` = 0.
- Back-to-back gates: same stimulus, `enable` held 1.
  - `valid` pulses every 1001 cycles.
  - Every `count_out` is 99 or 100.
  - `valid` is never high for 2 consecutive cycles.
- Saturation: CNT_W=4, GATE_CYCLES=200, `sig_in` period 4.
  - `count_out` = 15, `overflow` = 1.
  - Next gate with `sig_in` period 40 → `count_out` = 5, `overflow` = 0.
- Abort: drop `enable` at gate cycle 500 → no `valid`; the previously latched `count_out` is unchanged; `busy` = 0 on the next cycle.
- FREQ_METER_PERIOD_EN defined: `sig_in` period 37 cycles → after the second edge, `period_out` = 37. Repeat with period 8 → `period_out` = 8.
